// File: rtl/run_sequencer_pkg.sv
// run_seq_pkg: shared types and helpers for the run_sequencer block.
//   - run_state_e : sequencer state enum
//   - DEF_*       : default parameter values for the sequencer and its interface
//   - clog2_min1 / prog_width / phase_width : width helpers
//   - prog_entry  : default program entry-address table, compiled only when
//                   RUN_SEQ_PROG_TABLE_EN is defined
package run_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD_RST,
        PULSE_START,
        WAIT_ACK,
        DONE
    } run_state_e;

    localparam int unsigned DEF_NUM_PROGS    = 4;
    localparam int unsigned DEF_ADDR_W       = 8;
    localparam int unsigned DEF_RST_CYCLES   = 2;
    localparam int unsigned DEF_START_CYCLES = 1;
    localparam int unsigned DEF_TIMEOUT      = 1024;
    localparam int unsigned DEF_CNT_W        = 16;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of the program-select field.
    function automatic int unsigned prog_width(input int unsigned num_progs);
        return clog2_min1(num_progs);
    endfunction

    // The phase timer has to reach (longest phase - 1); the Ack timeout is the
    // longest phase when enabled.
    function automatic int unsigned phase_width(input int unsigned rst_cycles,
                                                input int unsigned start_cycles,
                                                input int unsigned timeout);
        int unsigned m;
        m = rst_cycles;
        if (start_cycles > m) m = start_cycles;
        if (timeout > m) m = timeout;
        return clog2_min1(m);
    endfunction

`ifdef RUN_SEQ_PROG_TABLE_EN
    // Entry address per program index; unused indices read as zero.
    function automatic logic [31:0] prog_entry(input int unsigned idx);
        logic [31:0] e;
        case (idx)
            0:       e = 32'h0000_0000;
            1:       e = 32'h0000_0020;
            2:       e = 32'h0000_0058;
            3:       e = 32'h0000_00E4;
            default: e = 32'h0000_0000;
        endcase
        return e;
    endfunction
`endif

endpackage

// File: rtl/run_sequencer_if.sv
// run_sequencer_if: host/core-side signal bundle of one run_sequencer.
//   Go, ProgSel          host -> sequencer run request and program index
//   DutAck               core -> sequencer done flag
//   DutReset, DutStart   sequencer -> core handshake
//   StartAddr            sequencer -> core entry address
//   Busy, Done, TimedOut, CycleCount  sequencer -> host status
// modport slave  : the sequencer
// modport master : the environment (host plus core)
interface run_sequencer_if #(
    parameter int unsigned NUM_PROGS = run_seq_pkg::DEF_NUM_PROGS,
    parameter int unsigned ADDR_W    = run_seq_pkg::DEF_ADDR_W,
    parameter int unsigned CNT_W     = run_seq_pkg::DEF_CNT_W
);
    import run_seq_pkg::*;

    localparam int unsigned PROG_W = prog_width(NUM_PROGS);

    logic              Go;
    logic [PROG_W-1:0] ProgSel;
    logic              DutAck;
    logic              DutReset;
    logic              DutStart;
    logic [ADDR_W-1:0] StartAddr;
    logic              Busy;
    logic              Done;
    logic              TimedOut;
    logic [CNT_W-1:0]  CycleCount;

    modport master (
        output Go, ProgSel, DutAck,
        input  DutReset, DutStart, StartAddr, Busy, Done, TimedOut, CycleCount
    );

    modport slave (
        input  Go, ProgSel, DutAck,
        output DutReset, DutStart, StartAddr, Busy, Done, TimedOut, CycleCount
    );

endinterface

// File: rtl/run_sequencer_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset (count -> 0)
//   clr   synchronous clear, has priority over en
//   en    count enable
//   q     current count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: drives a core's Reset/Start/Ack handshake for one run at a
// time: hold core in reset -> pulse Start -> wait for Ack (with optional
// timeout), measuring launch-to-Ack cycles in a saturating counter.
//   Clk    rising-edge clock
//   Reset  asynchronous active-low reset
//   bus    run_sequencer_if.slave (Go/ProgSel/DutAck in; DutReset, DutStart,
//          StartAddr, Busy, Done, TimedOut, CycleCount out; all registered)
// Build option RUN_SEQ_PROG_TABLE_EN: StartAddr comes from the package entry
// table; otherwise programs occupy equal slots, StartAddr = ProgSel << (ADDR_W-PROG_W).
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned NUM_PROGS    = DEF_NUM_PROGS,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
    parameter int unsigned START_CYCLES = DEF_START_CYCLES,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic           Clk,
    input  logic           Reset,
    run_sequencer_if.slave bus
);

    localparam int unsigned PROG_W     = prog_width(NUM_PROGS);
    localparam int unsigned PHASE_W    = phase_width(RST_CYCLES, START_CYCLES, TIMEOUT);
    localparam int unsigned RST_LAST   = RST_CYCLES - 1;
    localparam int unsigned START_LAST = START_CYCLES - 1;
    localparam int unsigned TO_LAST    = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    function automatic logic [ADDR_W-1:0] entry_addr(input logic [PROG_W-1:0] p);
`ifdef RUN_SEQ_PROG_TABLE_EN
        return ADDR_W'(prog_entry(32'(p)));
`else
        return ADDR_W'(p) << (ADDR_W - PROG_W);
`endif
    endfunction

    run_state_e        state, state_next;
    logic              accept, abort, timeout_hit;
    logic [PROG_W-1:0] prog_idx;
    logic [PHASE_W-1:0] phase;

    logic              dut_reset_q, dut_reset_next;
    logic              dut_start_q, dut_start_next;
    logic              busy_q, busy_next;
    logic              done_q, done_next;
    logic              timed_out_q, timed_out_next;
    logic [ADDR_W-1:0] start_addr_q;
    logic [CNT_W-1:0]  cycle_count;

    assign prog_idx    = (32'(bus.ProgSel) < NUM_PROGS) ? bus.ProgSel : '0;
    assign timeout_hit = (TIMEOUT != 0) && (phase == PHASE_W'(TO_LAST));

    // Cycles spent in the current state; restarts on every state change so
    // each phase length is a simple compare.
    sat_counter #(.W(PHASE_W)) u_phase (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (state_next != state),
        .en    (1'b1),
        .q     (phase)
    );

    // Launch-to-Ack measurement; the Ack cycle itself is not counted.
    sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (accept),
        .en    ((state == WAIT_ACK) && !bus.DutAck),
        .q     (cycle_count)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.Go) begin
                    state_next = HOLD_RST;
                    accept     = 1'b1;
                end
            end
            HOLD_RST: begin
                if (phase == PHASE_W'(RST_LAST)) state_next = PULSE_START;
            end
            PULSE_START: begin
                if (phase == PHASE_W'(START_LAST)) state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Ack has priority over a timeout landing on the same cycle.
                if (bus.DutAck) begin
                    state_next = DONE;
                end else if (timeout_hit) begin
                    state_next = DONE;
                    abort      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        timed_out_next = timed_out_q;
        if (accept) begin
            timed_out_next = 1'b0;
        end else if (abort) begin
            timed_out_next = 1'b1;
        end

        // Outputs are decoded from the next state so they can be registered
        // without adding a cycle of latency.
        dut_reset_next = 1'b0;
        dut_start_next = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        case (state_next)
            IDLE:        dut_reset_next = 1'b1;
            HOLD_RST: begin
                dut_reset_next = 1'b1;
                busy_next      = 1'b1;
            end
            PULSE_START: begin
                dut_start_next = 1'b1;
                busy_next      = 1'b1;
            end
            WAIT_ACK:    busy_next = 1'b1;
            DONE: begin
                // Core stays out of reset after a clean Ack so its memory can be read.
                dut_reset_next = timed_out_next;
                done_next      = 1'b1;
            end
            default:     dut_reset_next = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            dut_reset_q  <= 1'b1;
            dut_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timed_out_q  <= 1'b0;
            start_addr_q <= entry_addr('0);
        end else begin
            state       <= state_next;
            dut_reset_q <= dut_reset_next;
            dut_start_q <= dut_start_next;
            busy_q      <= busy_next;
            done_q      <= done_next;
            timed_out_q <= timed_out_next;
            if (accept) begin
                start_addr_q <= entry_addr(prog_idx);
            end
        end
    end

    assign bus.DutReset   = dut_reset_q;
    assign bus.DutStart   = dut_start_q;
    assign bus.StartAddr  = start_addr_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.TimedOut   = timed_out_q;
    assign bus.CycleCount = cycle_count;

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: three run_sequencer instances sharing Go/ProgSel/Reset,
// each with its own DutAck:
//   d0: defaults (TIMEOUT=1024, CNT_W=16)
//   d1: TIMEOUT=16
//   d2: NUM_PROGS=3, CNT_W=4, TIMEOUT=0
// Expected outputs come from a per-instance model that tracks only
// "cycles since the run was accepted" and derives each output arithmetically.
module tb_run_sequencer;

    localparam int R = 2;
    localparam int S = 1;

    int to_p [3] = '{1024, 16, 0};
    int cmax [3] = '{65535, 65535, 15};
    int np   [3] = '{4, 4, 3};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       go;
    logic [1:0] prog_sel;
    logic       ack [3];

    always #5 clk = ~clk;

    run_sequencer_if #(.NUM_PROGS(4), .ADDR_W(8), .CNT_W(16)) if0 ();
    run_sequencer_if #(.NUM_PROGS(4), .ADDR_W(8), .CNT_W(16)) if1 ();
    run_sequencer_if #(.NUM_PROGS(3), .ADDR_W(8), .CNT_W(4))  if2 ();

    run_sequencer #(.NUM_PROGS(4), .ADDR_W(8), .RST_CYCLES(2), .START_CYCLES(1),
                    .TIMEOUT(1024), .CNT_W(16))
        dut0 (.Clk(clk), .Reset(rst_n), .bus(if0));
    run_sequencer #(.NUM_PROGS(4), .ADDR_W(8), .RST_CYCLES(2), .START_CYCLES(1),
                    .TIMEOUT(16), .CNT_W(16))
        dut1 (.Clk(clk), .Reset(rst_n), .bus(if1));
    run_sequencer #(.NUM_PROGS(3), .ADDR_W(8), .RST_CYCLES(2), .START_CYCLES(1),
                    .TIMEOUT(0), .CNT_W(4))
        dut2 (.Clk(clk), .Reset(rst_n), .bus(if2));

    assign if0.Go = go;  assign if0.ProgSel = prog_sel;  assign if0.DutAck = ack[0];
    assign if1.Go = go;  assign if1.ProgSel = prog_sel;  assign if1.DutAck = ack[1];
    assign if2.Go = go;  assign if2.ProgSel = prog_sel;  assign if2.DutAck = ack[2];

    logic        o_rst [3], o_start [3], o_busy [3], o_done [3], o_to [3];
    logic [15:0] o_cnt [3];
    logic [7:0]  o_addr [3];

    assign o_rst[0] = if0.DutReset;   assign o_start[0] = if0.DutStart;
    assign o_busy[0] = if0.Busy;      assign o_done[0] = if0.Done;
    assign o_to[0] = if0.TimedOut;    assign o_cnt[0] = if0.CycleCount;
    assign o_addr[0] = if0.StartAddr;
    assign o_rst[1] = if1.DutReset;   assign o_start[1] = if1.DutStart;
    assign o_busy[1] = if1.Busy;      assign o_done[1] = if1.Done;
    assign o_to[1] = if1.TimedOut;    assign o_cnt[1] = if1.CycleCount;
    assign o_addr[1] = if1.StartAddr;
    assign o_rst[2] = if2.DutReset;   assign o_start[2] = if2.DutStart;
    assign o_busy[2] = if2.Busy;      assign o_done[2] = if2.Done;
    assign o_to[2] = if2.TimedOut;    assign o_cnt[2] = 16'(if2.CycleCount);
    assign o_addr[2] = if2.StartAddr;

    // Model: mode 0 = never run / reset, 1 = run in progress, 2 = run finished.
    int m_mode [3];
    int m_k    [3];   // cycles since the accepting edge (1 = first HOLD cycle)
    int m_cnt  [3];   // final cycle count of a finished run (unsaturated)
    bit m_to   [3];
    int m_prog [3];
    int ack_at [3];   // WAIT cycle index at which Ack rises; -1 = never

    int  checks = 0;
    int  passes = 0;
    int  rst_hi = 0;
    int  start_hi = 0;
    bit  reroll = 1'b0;

    function automatic logic [7:0] exp_addr(input int p);
        logic [7:0] a;
`ifdef RUN_SEQ_PROG_TABLE_EN
        case (p)
            0: a = 8'h00;
            1: a = 8'h20;
            2: a = 8'h58;
            3: a = 8'hE4;
            default: a = 8'h00;
        endcase
`else
        a = 8'(p * 64);
`endif
        return a;
    endfunction

    function automatic int sat(input int i, input int v);
        return (v > cmax[i]) ? cmax[i] : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int w;
            int e_cnt;
            bit e_rst;
            w = m_k[i] - R - S - 1;
            e_rst = (m_mode[i] == 0) || (m_mode[i] == 1 && m_k[i] <= R) ||
                    (m_mode[i] == 2 && m_to[i]);
            if (m_mode[i] == 1)      e_cnt = (w > 0) ? sat(i, w) : 0;
            else if (m_mode[i] == 2) e_cnt = sat(i, m_cnt[i]);
            else                     e_cnt = 0;
            check($sformatf("d%0d_DutReset", i), 32'(o_rst[i]), 32'(e_rst));
            check($sformatf("d%0d_DutStart", i), 32'(o_start[i]),
                  32'(m_mode[i] == 1 && m_k[i] > R && m_k[i] <= R + S));
            check($sformatf("d%0d_Busy", i), 32'(o_busy[i]), 32'(m_mode[i] == 1));
            check($sformatf("d%0d_Done", i), 32'(o_done[i]), 32'(m_mode[i] == 2));
            check($sformatf("d%0d_TimedOut", i), 32'(o_to[i]), 32'(m_mode[i] == 2 && m_to[i]));
            check($sformatf("d%0d_CycleCount", i), 32'(o_cnt[i]), 32'(e_cnt));
            check($sformatf("d%0d_StartAddr", i), 32'(o_addr[i]), 32'(exp_addr(m_prog[i])));
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_k[i] = 0; m_cnt[i] = 0; m_to[i] = 1'b0; m_prog[i] = 0;
        end
    endfunction

    function automatic void model_step();
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_mode[i] = 0; m_k[i] = 0; m_cnt[i] = 0; m_to[i] = 1'b0; m_prog[i] = 0;
            end else if (m_mode[i] != 1) begin
                if (go) begin
                    m_mode[i] = 1;
                    m_k[i]    = 1;
                    m_cnt[i]  = 0;
                    m_to[i]   = 1'b0;
                    m_prog[i] = (int'(prog_sel) < np[i]) ? int'(prog_sel) : 0;
                end
            end else begin
                int w;
                w = m_k[i] - R - S - 1;
                if (w >= 0 && ack[i]) begin
                    m_mode[i] = 2;
                    m_cnt[i]  = w;
                end else if (w >= 0 && to_p[i] != 0 && w + 1 == to_p[i]) begin
                    m_mode[i] = 2;
                    m_cnt[i]  = w + 1;
                    m_to[i]   = 1'b1;
                end else begin
                    m_k[i]++;
                end
            end
        end
    endfunction

    // Ack follows the planned WAIT index; outside WAIT it toggles randomly
    // since the sequencer must ignore it there.
    function automatic logic ack_level(input int i);
        int w;
        w = m_k[i] - R - S - 1;
        if (m_mode[i] == 1 && w >= 0) return (ack_at[i] >= 0) && (w >= ack_at[i]);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic tick(input logic g, input logic [1:0] ps, input logic r);
        int prev [3];
        @(negedge clk);
        check_all();
        if (o_busy[0] && o_rst[0]) rst_hi++;
        if (o_start[0]) start_hi++;
        rst_n = r;
        go = g;
        prog_sel = ps;
        for (int i = 0; i < 3; i++) ack[i] = ack_level(i);
        for (int i = 0; i < 3; i++) prev[i] = m_mode[i];
        model_step();
        if (reroll)
            for (int i = 0; i < 3; i++)
                if (prev[i] != 1 && m_mode[i] == 1) ack_at[i] = int'($urandom_range(0, 40));
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while ((m_mode[0] == 1 || m_mode[1] == 1 || m_mode[2] == 1) && n < budget) begin
            tick(1'b0, 2'd0, 1'b1);
            n++;
        end
        checks++;
        if (n < budget) passes++;
        else $display("FAIL run_budget: run still busy after %0d cycles, expected to finish", n);
        // One more edge so the DUT catches up with the model before literal checks.
        tick(1'b0, 2'd0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        go = 1'b0;
        prog_sel = 2'd0;
        for (int i = 0; i < 3; i++) begin ack[i] = 1'b0; ack_at[i] = 0; end
        model_reset();

        // Reset state.
        tick(1'b0, 2'd0, 1'b0);
        tick(1'b0, 2'd0, 1'b0);
        check("rst_d0_DutReset", 32'(o_rst[0]), 32'd1);
        check("rst_d0_StartAddr", 32'(o_addr[0]), 32'h00);
        check("rst_d1_Busy", 32'(o_busy[1]), 32'd0);

        // Run A: ProgSel 0; d0 Ack after 40, d1 Ack on its 16th WAIT cycle,
        // d2 saturates at 15. Go pulses while busy must be ignored.
        ack_at = '{40, 15, 30};
        rst_hi = 0;
        start_hi = 0;
        tick(1'b1, 2'd0, 1'b1);
        tick(1'b1, 2'd3, 1'b1);
        tick(1'b1, 2'd2, 1'b1);
        run_until_done(300);
        check("a_d0_CycleCount", 32'(o_cnt[0]), 32'd40);
        check("a_d0_Done", 32'(o_done[0]), 32'd1);
        check("a_d0_TimedOut", 32'(o_to[0]), 32'd0);
        check("a_d0_DutReset", 32'(o_rst[0]), 32'd0);
        check("a_d0_StartAddr", 32'(o_addr[0]), 32'h00);
        check("a_d0_reset_cycles", 32'(rst_hi), 32'd2);
        check("a_d0_start_cycles", 32'(start_hi), 32'd1);
        check("a_d1_CycleCount", 32'(o_cnt[1]), 32'd15);
        check("a_d1_TimedOut", 32'(o_to[1]), 32'd0);
        check("a_d2_CycleCount", 32'(o_cnt[2]), 32'd15);

        // Run B: d1 never gets Ack and must time out at 16.
        ack_at = '{20, -1, 8};
        tick(1'b1, 2'd2, 1'b1);
        run_until_done(300);
        check("b_d1_TimedOut", 32'(o_to[1]), 32'd1);
        check("b_d1_CycleCount", 32'(o_cnt[1]), 32'd16);
        check("b_d1_DutReset", 32'(o_rst[1]), 32'd1);
        check("b_d1_Done", 32'(o_done[1]), 32'd1);
        check("b_d0_CycleCount", 32'(o_cnt[0]), 32'd20);
        check("b_d2_CycleCount", 32'(o_cnt[2]), 32'd8);

        // ProgSel 3, then Go in DONE relatches ProgSel 1.
        ack_at = '{5, 5, 5};
        tick(1'b1, 2'd3, 1'b1);
        run_until_done(300);
`ifdef RUN_SEQ_PROG_TABLE_EN
        check("p_d0_StartAddr", 32'(o_addr[0]), 32'hE4);
`else
        check("p_d0_StartAddr", 32'(o_addr[0]), 32'hC0);
`endif
        check("p_d2_StartAddr_oor", 32'(o_addr[2]), 32'h00);
        tick(1'b1, 2'd1, 1'b1);
        tick(1'b0, 2'd0, 1'b1);
`ifdef RUN_SEQ_PROG_TABLE_EN
        check("p2_d0_StartAddr", 32'(o_addr[0]), 32'h20);
`else
        check("p2_d0_StartAddr", 32'(o_addr[0]), 32'h40);
`endif
        check("p2_d0_Done", 32'(o_done[0]), 32'd0);
        check("p2_d0_Busy", 32'(o_busy[0]), 32'd1);
        run_until_done(300);

        // Reset asserted mid-WAIT_ACK: outputs return to reset values at once.
        ack_at = '{50, 50, 50};
        tick(1'b1, 2'd2, 1'b1);
        repeat (10) tick(1'b0, 2'd0, 1'b1);
        @(negedge clk);
        check_all();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("mr_d0_Busy", 32'(o_busy[0]), 32'd0);
        check("mr_d0_CycleCount", 32'(o_cnt[0]), 32'd0);
        check("mr_d0_DutReset", 32'(o_rst[0]), 32'd1);
        check("mr_d0_StartAddr", 32'(o_addr[0]), 32'h00);
        tick(1'b0, 2'd0, 1'b0);
        tick(1'b0, 2'd0, 1'b1);

        // Randomised traffic, including occasional resets.
        reroll = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            tick(1'($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 499) != 0));
        end
        tick(1'b0, 2'd0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
